// File: rtl/wb_irq_ctrl_pkg.sv
// Shared constants and types for the wishbone interrupt controller.
package wb_irq_ctrl_pkg;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_EDGE    = 2'd2;
  localparam logic [1:0] REG_CLAIM   = 2'd3;

  localparam int ID_W = 5;
  localparam logic [ID_W-1:0] CLAIM_NONE = '0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_irq_ctrl_if.sv
// Wishbone slave bus bundle for the interrupt controller.
interface wb_irq_ctrl_if #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_SEL_WIDTH  = 4
);
  logic [WB_ADDR_WIDTH-1:0] wb_addr_i;
  logic [WB_DATA_WIDTH-1:0] wb_data_i;
  logic                     wb_we_i;
  logic [WB_SEL_WIDTH-1:0]  wb_sel_i;
  logic                     wb_stb_i;
  logic                     wb_cyc_i;
  logic                     wb_ack_o;
  logic [WB_DATA_WIDTH-1:0] wb_data_o;

  modport master (
    output wb_addr_i, wb_data_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_ack_o, wb_data_o
  );

  modport slave (
    input  wb_addr_i, wb_data_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_ack_o, wb_data_o
  );
endinterface

// File: rtl/wb_irq_ctrl_prio_enc.sv
// Lowest-index-first priority encoder over the pending&enabled vector.
module irq_prio_enc
  import wb_irq_ctrl_pkg::*;
#(
  parameter int N_IRQ = 4
) (
  input  logic [N_IRQ-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_irq_ctrl.sv
// Wishbone interrupt controller: pending/enable/edge registers, claim port, registered irq_o.
// state   | meaning
// ST_IDLE | waiting for a request; register side-effects happen on the leaving edge
// ST_ACK  | wb_ack_o high for one cycle, new requests masked
module wb_irq_ctrl
  import wb_irq_ctrl_pkg::*;
#(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_SEL_WIDTH  = 4,
  parameter int N_IRQ         = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_irq_ctrl_if.slave     wb,
  input  logic [N_IRQ-1:0] irq_i,
  output logic             irq_o
);

  wb_state_t state, state_nxt;
  logic req, wr_en, rd_en;
  logic [1:0] reg_idx;
  logic [N_IRQ-1:0] pending, enable, edge_sel, irq_q;
  logic [N_IRQ-1:0] pend_nxt, wmask, clr, rise;
  logic [WB_DATA_WIDTH-1:0] rd_val;
  logic prio_valid;
  logic [ID_W-1:0] prio_id, claim_id;
  logic unused_bits;

  assign unused_bits = ^{wb.wb_addr_i, wb.wb_data_i, wb.wb_sel_i};

  assign reg_idx = wb.wb_addr_i[3:2];
  assign req     = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
  assign wr_en   = req & wb.wb_we_i;
  assign rd_en   = req & ~wb.wb_we_i;
  assign rise    = irq_i & ~irq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wb.wb_ack_o = (state == ST_ACK);
  end

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio (
    .req   (pending & enable),
    .valid (prio_valid),
    .id    (prio_id)
  );

  assign claim_id = prio_valid ? prio_id + ID_W'(1) : CLAIM_NONE;

  always_comb begin
    for (int i = 0; i < N_IRQ; i++) wmask[i] = wb.wb_sel_i[i / 8];
  end

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_PENDING: rd_val[N_IRQ-1:0] = pending;
      REG_ENABLE:  rd_val[N_IRQ-1:0] = enable;
      REG_EDGE:    rd_val[N_IRQ-1:0] = edge_sel;
      default:     rd_val[ID_W-1:0]  = claim_id;
    endcase
  end

  // A rising edge in the same cycle as a clear keeps the bit set.
  always_comb begin
    clr = '0;
    if (wr_en && reg_idx == REG_PENDING) clr = wb.wb_data_i[N_IRQ-1:0] & wmask;
    for (int i = 0; i < N_IRQ; i++) begin
      if (rd_en && reg_idx == REG_CLAIM && prio_valid && prio_id == ID_W'(i)) clr[i] = 1'b1;
    end
    for (int i = 0; i < N_IRQ; i++) begin
      pend_nxt[i] = edge_sel[i] ? (rise[i] | (pending[i] & ~clr[i])) : irq_i[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending      <= '0;
      enable       <= '0;
      edge_sel     <= '0;
      irq_q        <= '0;
      irq_o        <= 1'b0;
      wb.wb_data_o <= '0;
    end else begin
      irq_q   <= irq_i;
      irq_o   <= |(pending & enable);
      pending <= pend_nxt;
      if (req) wb.wb_data_o <= rd_val;
      if (wr_en && reg_idx == REG_ENABLE)
        enable <= (enable & ~wmask) | (wb.wb_data_i[N_IRQ-1:0] & wmask);
      if (wr_en && reg_idx == REG_EDGE)
        edge_sel <= (edge_sel & ~wmask) | (wb.wb_data_i[N_IRQ-1:0] & wmask);
    end
  end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Randomized and directed bench for wb_irq_ctrl against a per-source behavioural model.
module tb_wb_irq_ctrl;

  localparam int NI = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  logic [NI-1:0] irq_i;
  logic irq_o;
  logic [NI-1:0] irq_drv;

  int n_chk = 0;
  int n_bad = 0;

  bit m_pend[NI];
  bit m_en[NI];
  bit m_edge[NI];
  bit m_prev[NI];
  bit m_irq;

  wb_irq_ctrl_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .WB_SEL_WIDTH(4)) wbif ();

  wb_irq_ctrl #(
    .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .WB_SEL_WIDTH(4), .N_IRQ(NI)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wb    (wbif),
    .irq_i (irq_i),
    .irq_o (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_pend[i] = 0; m_en[i] = 0; m_edge[i] = 0; m_prev[i] = 0;
    end
    m_irq = 0;
  endtask

  // One clock of the source/register behaviour, evaluated from the pre-edge state.
  task automatic model_step(input bit bus, input bit we, input logic [1:0] idx,
                            input logic [31:0] wd, input logic [3:0] sel,
                            input logic [NI-1:0] irq, output logic [31:0] erd);
    int cid;
    bit pn[NI];
    bit lane, clear, rise;
    cid = 0;
    for (int i = 0; i < NI; i++)
      if (cid == 0 && m_pend[i] && m_en[i]) cid = i + 1;
    erd = '0;
    for (int i = 0; i < NI; i++) begin
      case (idx)
        2'd0: erd[i] = m_pend[i];
        2'd1: erd[i] = m_en[i];
        2'd2: erd[i] = m_edge[i];
        default: ;
      endcase
    end
    if (idx == 2'd3) erd = 32'(cid);
    m_irq = (cid != 0);
    for (int i = 0; i < NI; i++) begin
      lane  = sel[i / 8];
      clear = (bus && we && idx == 2'd0 && wd[i] && lane) ||
              (bus && !we && idx == 2'd3 && cid == i + 1);
      rise  = irq[i] && !m_prev[i];
      pn[i] = m_edge[i] ? (rise || (m_pend[i] && !clear)) : irq[i];
    end
    for (int i = 0; i < NI; i++) begin
      lane = sel[i / 8];
      if (bus && we && lane && idx == 2'd1) m_en[i] = wd[i];
      if (bus && we && lane && idx == 2'd2) m_edge[i] = wd[i];
      m_pend[i] = pn[i];
      m_prev[i] = irq[i];
    end
  endtask

  task automatic do_cycle(input bit bus, input bit we, input logic [1:0] idx,
                          input logic [31:0] wd, input logic [3:0] sel,
                          output logic [31:0] erd);
    wbif.wb_cyc_i  = bus;
    wbif.wb_stb_i  = bus;
    wbif.wb_we_i   = we;
    wbif.wb_addr_i = {28'h0, idx, 2'b00};
    wbif.wb_data_i = wd;
    wbif.wb_sel_i  = sel;
    irq_i          = irq_drv;
    model_step(bus, we, idx, wd, sel, irq_drv, erd);
    @(posedge clk_i); #1;
    chk("irq_o", {31'h0, irq_o}, {31'h0, m_irq});
    chk("ack", {31'h0, wbif.wb_ack_o}, {31'h0, bus});
  endtask

  task automatic idle(input int n);
    logic [31:0] d;
    for (int k = 0; k < n; k++) do_cycle(0, 0, 2'd0, 32'h0, 4'h0, d);
  endtask

  task automatic bus_op(input bit we, input logic [1:0] idx, input logic [31:0] wd,
                        input logic [3:0] sel, output logic [31:0] rd_act);
    logic [31:0] erd, dummy;
    do_cycle(1, we, idx, wd, sel, erd);
    rd_act = wbif.wb_data_o;
    if (!we) chk("rdata", rd_act, erd);
    do_cycle(0, 0, idx, 32'h0, 4'h0, dummy);
  endtask

  task automatic do_reset();
    irq_drv = '0;
    irq_i   = '0;
    wbif.wb_cyc_i = 0; wbif.wb_stb_i = 0; wbif.wb_we_i = 0;
    wbif.wb_addr_i = '0; wbif.wb_data_i = '0; wbif.wb_sel_i = '0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    model_reset();
  endtask

  logic [31:0] rd;

  initial begin
    do_reset();
    chk("rst_irq_o", {31'h0, irq_o}, 32'h0);
    chk("rst_ack", {31'h0, wbif.wb_ack_o}, 32'h0);

    // 1: every register reads zero after reset
    for (int r = 0; r < 4; r++) begin
      bus_op(0, 2'(r), 32'h0, 4'hF, rd);
      chk("rst_read", rd, 32'h0);
    end

    // 2: level source
    bus_op(1, 2'd1, 32'h1, 4'hF, rd);
    bus_op(1, 2'd2, 32'h0, 4'hF, rd);
    irq_drv = 4'h1;
    idle(1);
    chk("lvl_irq_lat1", {31'h0, irq_o}, 32'h0);
    idle(1);
    chk("lvl_irq_lat2", {31'h0, irq_o}, 32'h1);
    bus_op(0, 2'd3, 32'h0, 4'hF, rd);
    chk("lvl_claim", rd, 32'h1);
    chk("lvl_irq_held", {31'h0, irq_o}, 32'h1);
    irq_drv = 4'h0;
    idle(2);
    chk("lvl_irq_drop", {31'h0, irq_o}, 32'h0);

    // 3: edge source
    bus_op(1, 2'd2, 32'h2, 4'hF, rd);
    bus_op(1, 2'd1, 32'h2, 4'hF, rd);
    irq_drv = 4'h2; idle(1);
    irq_drv = 4'h0; idle(2);
    bus_op(0, 2'd0, 32'h0, 4'hF, rd);
    chk("edge_pend", rd, 32'h2);
    chk("edge_irq", {31'h0, irq_o}, 32'h1);
    bus_op(0, 2'd3, 32'h0, 4'hF, rd);
    chk("edge_claim", rd, 32'h2);
    bus_op(0, 2'd0, 32'h0, 4'hF, rd);
    chk("edge_pend_clr", rd, 32'h0);
    chk("edge_irq_clr", {31'h0, irq_o}, 32'h0);

    // 4: priority among edge sources
    bus_op(1, 2'd2, 32'hF, 4'hF, rd);
    bus_op(1, 2'd1, 32'hC, 4'hF, rd);
    irq_drv = 4'hF; idle(1);
    irq_drv = 4'h0; idle(1);
    bus_op(0, 2'd0, 32'h0, 4'hF, rd);
    chk("prio_pend", rd, 32'hF);
    bus_op(0, 2'd3, 32'h0, 4'hF, rd);
    chk("prio_claim_a", rd, 32'h3);
    bus_op(0, 2'd3, 32'h0, 4'hF, rd);
    chk("prio_claim_b", rd, 32'h4);
    bus_op(0, 2'd3, 32'h0, 4'hF, rd);
    chk("prio_claim_c", rd, 32'h0);
    bus_op(0, 2'd0, 32'h0, 4'hF, rd);
    chk("prio_pend_end", rd, 32'h3);
    bus_op(1, 2'd3, 32'hFFFF_FFFF, 4'hF, rd);
    bus_op(0, 2'd0, 32'h0, 4'hF, rd);
    chk("claim_wr_noeff", rd, 32'h3);

    // 5: W1C colliding with a rising edge on the same bit
    irq_drv = 4'h0;
    bus_op(1, 2'd0, 32'hF, 4'hF, rd);
    irq_drv = 4'h1;
    bus_op(1, 2'd0, 32'h1, 4'hF, rd);
    bus_op(0, 2'd0, 32'h0, 4'hF, rd);
    chk("collide_pend", rd & 32'h1, 32'h1);
    irq_drv = 4'h0;

    // 6: byte lanes
    bus_op(1, 2'd1, 32'hFFFF_FFFF, 4'b0001, rd);
    bus_op(0, 2'd1, 32'h0, 4'hF, rd);
    chk("sel_enable", rd, 32'hF);
    bus_op(1, 2'd1, 32'h0, 4'b1110, rd);
    bus_op(0, 2'd1, 32'h0, 4'hF, rd);
    chk("sel_masked", rd, 32'hF);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      irq_drv = NI'($urandom);
      if ($urandom_range(0, 3) == 0) idle(1);
      else bus_op(1'($urandom), 2'($urandom), $urandom, 4'($urandom), rd);
    end

    // 6: reset landing on a request cycle suppresses the ack
    irq_drv = 4'h0;
    wbif.wb_cyc_i = 1; wbif.wb_stb_i = 1; wbif.wb_we_i = 1;
    wbif.wb_addr_i = 32'h4; wbif.wb_data_i = 32'hF; wbif.wb_sel_i = 4'hF;
    irq_i = 4'h0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_mid_ack", {31'h0, wbif.wb_ack_o}, 32'h0);
    wbif.wb_cyc_i = 0; wbif.wb_stb_i = 0;
    @(posedge clk_i); #1;
    chk("rst_mid_ack2", {31'h0, wbif.wb_ack_o}, 32'h0);
    rst_i = 1'b0;
    model_reset();
    idle(1);
    for (int r = 0; r < 4; r++) begin
      bus_op(0, 2'(r), 32'h0, 4'hF, rd);
      chk("rst_mid_read", rd, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
